// File: rtl/traffic_light_ctrl_param.sv
// Purpose: highway/side-road traffic light FSM with a tick prescaler, per-phase tick counts and optional all-red.
// Latency: lamps and state_o are registered and change together; a request can be acted on the edge it is seen.
// Backpressure: none; car_sr is a level and ped_req a pulse, both sampled every cycle with no handshake.
//
// Ports:
//   clk            system clock
//   rst_n          asynchronous active-low reset
//   car_sr         side-road vehicle sensor (level, synchronous to clk)
//   ped_req        pedestrian request pulse (only used when TL_PED_EN is defined)
//   light_highway  highway lamps {red,yellow,green}, one-hot, registered
//   light_SR       side-road lamps {red,yellow,green}, one-hot, registered
//   walk           pedestrian walk lamp, registered (tied low without TL_PED_EN)
//   state_o        current FSM state encoding, for debug
//
// Build option: define TL_PED_EN to add the pedestrian request latch and the walk lamp.
module traffic_light_ctrl_param #(
    parameter int TICK_DIV     = 50000000,
    parameter int CNT_W        = 8,
    parameter int MIN_HGREEN_S = 5,
    parameter int YEL_S        = 3,
    parameter int ALLRED_S     = 1,
    parameter int SGREEN_S     = 10
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       car_sr,
    input  logic       ped_req,
    output logic [2:0] light_highway,
    output logic [2:0] light_SR,
    output logic       walk,
    output logic [2:0] state_o
);

    localparam int PRESC_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

    // Last sec_cnt value of each phase: the phase ends on the tick seen with this count.
    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICK_DIV - 1);
    localparam logic [CNT_W-1:0]   MIN_LAST   = CNT_W'(MIN_HGREEN_S - 1);
    localparam logic [CNT_W-1:0]   YEL_LAST   = CNT_W'(YEL_S - 1);
    localparam logic [CNT_W-1:0]   SGRE_LAST  = CNT_W'(SGREEN_S - 1);
    localparam logic [CNT_W-1:0]   ARED_LAST  = (ALLRED_S == 0) ? '0 : CNT_W'(ALLRED_S - 1);
    localparam logic [CNT_W-1:0]   CNT_MAX    = '1;

    typedef enum logic [2:0] {
        HGRE  = 3'd0,
        HYEL  = 3'd1,
        ARED1 = 3'd2,
        SGRE  = 3'd3,
        SYEL  = 3'd4,
        ARED2 = 3'd5
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [PRESC_W-1:0] presc;
    logic [CNT_W-1:0]   sec_cnt;
    logic               sr_req;
    logic               tick;
    logic               hw_req;
    logic               enter_sgre;
    logic               leave_sgre;

    // Lamp decode from a state; illegal encodings never reach the lamp registers
    // because the next-state logic maps them to HGRE.
    function automatic logic [2:0] hw_lamp(input state_t s);
        case (s)
            HGRE:    hw_lamp = 3'b001;
            HYEL:    hw_lamp = 3'b010;
            default: hw_lamp = 3'b100;
        endcase
    endfunction

    function automatic logic [2:0] sr_lamp(input state_t s);
        case (s)
            SGRE:    sr_lamp = 3'b001;
            SYEL:    sr_lamp = 3'b010;
            default: sr_lamp = 3'b100;
        endcase
    endfunction

    assign tick       = (presc == PRESC_LAST);
    assign enter_sgre = (state_nxt == SGRE) && (state != SGRE);
    assign leave_sgre = (state == SGRE) && (state_nxt != SGRE);
    assign state_o    = state;

`ifdef TL_PED_EN
    logic ped_latch;
    // Live inputs are ORed in so a request coinciding with the min-green tick
    // still moves the FSM on that same edge.
    assign hw_req = sr_req | car_sr | ped_latch | ped_req;
`else
    // Pedestrian input has no function in this build.
    logic unused_ped_req;
    assign unused_ped_req = ped_req;
    assign hw_req         = sr_req | car_sr;
    assign walk           = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        case (state)
            HGRE: begin
                if (tick && (sec_cnt >= MIN_LAST) && hw_req)
                    state_nxt = HYEL;
            end
            HYEL: begin
                if (tick && (sec_cnt == YEL_LAST))
                    state_nxt = (ALLRED_S == 0) ? SGRE : ARED1;
            end
            ARED1: begin
                if (tick && (sec_cnt == ARED_LAST))
                    state_nxt = SGRE;
            end
            SGRE: begin
                // Side green length is fixed; car_sr does not extend it.
                if (tick && (sec_cnt == SGRE_LAST))
                    state_nxt = SYEL;
            end
            SYEL: begin
                if (tick && (sec_cnt == YEL_LAST))
                    state_nxt = (ALLRED_S == 0) ? HGRE : ARED2;
            end
            ARED2: begin
                if (tick && (sec_cnt == ARED_LAST))
                    state_nxt = HGRE;
            end
            default: state_nxt = HGRE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= HGRE;
            light_highway <= 3'b001;
            light_SR      <= 3'b100;
            presc         <= '0;
            sec_cnt       <= '0;
            sr_req        <= 1'b0;
`ifdef TL_PED_EN
            ped_latch     <= 1'b0;
            walk          <= 1'b0;
`endif
        end else begin
            state         <= state_nxt;
            light_highway <= hw_lamp(state_nxt);
            light_SR      <= sr_lamp(state_nxt);

            // Timing restarts on every state change so each phase is exactly
            // its tick count times TICK_DIV cycles long.
            if (state_nxt != state) begin
                presc   <= '0;
                sec_cnt <= '0;
            end else begin
                presc <= tick ? '0 : presc + PRESC_W'(1);
                if (tick && (sec_cnt != CNT_MAX))
                    sec_cnt <= sec_cnt + CNT_W'(1);
            end

            // The request is served once side green starts; a sensor pulse on
            // that exact edge is dropped, a held sensor re-arms next cycle.
            if (enter_sgre)
                sr_req <= 1'b0;
            else if (car_sr)
                sr_req <= 1'b1;

`ifdef TL_PED_EN
            if (enter_sgre)
                ped_latch <= 1'b0;
            else if (ped_req)
                ped_latch <= 1'b1;

            if (enter_sgre)
                walk <= ped_latch;
            else if (leave_sgre)
                walk <= 1'b0;
`endif
        end
    end

`ifndef TL_PED_EN
    // Only the pedestrian build needs the SGRE exit strobe.
    logic unused_leave_sgre;
    assign unused_leave_sgre = leave_sgre;
`endif

endmodule

// File: tb/tb_traffic_light_ctrl_param.sv
// Purpose: self-checking bench for traffic_light_ctrl_param (one DUT with all-red, one without).
// Latency: phase lengths are measured in cycles and compared to a queue of expected phases.
// Backpressure: not applicable; stimulus is driven on fixed cycles after reset release.
module tb_traffic_light_ctrl_param;

    localparam int ST_HGRE  = 0;
    localparam int ST_HYEL  = 1;
    localparam int ST_ARED1 = 2;
    localparam int ST_SGRE  = 3;
    localparam int ST_SYEL  = 4;
    localparam int ST_ARED2 = 5;

    typedef struct packed {
        logic [2:0] st;
        int         len;
    } phase_t;

    logic       clk;
    logic       rst_n;
    logic       car_a;
    logic       car_b;
    logic       ped_req;
    logic [2:0] hw_a, sr_a, state_a;
    logic [2:0] hw_b, sr_b, state_b;
    logic       walk_a, walk_b;

    int n_checks = 0;
    int n_errors = 0;

    phase_t q_a[$];
    phase_t q_b[$];
    logic [2:0] cur_a, cur_b;
    int         len_a, len_b;
    logic       ped_mode;
    logic       ared_seen_b;

    traffic_light_ctrl_param #(
        .TICK_DIV(4), .CNT_W(8), .MIN_HGREEN_S(5), .YEL_S(3), .ALLRED_S(1), .SGREEN_S(10)
    ) dut_a (
        .clk(clk), .rst_n(rst_n), .car_sr(car_a), .ped_req(ped_req),
        .light_highway(hw_a), .light_SR(sr_a), .walk(walk_a), .state_o(state_a)
    );

    traffic_light_ctrl_param #(
        .TICK_DIV(4), .CNT_W(8), .MIN_HGREEN_S(5), .YEL_S(3), .ALLRED_S(0), .SGREEN_S(10)
    ) dut_b (
        .clk(clk), .rst_n(rst_n), .car_sr(car_b), .ped_req(ped_req),
        .light_highway(hw_b), .light_SR(sr_b), .walk(walk_b), .state_o(state_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    function automatic logic [2:0] exp_hw(input logic [2:0] s);
        case (s)
            3'd0:    return 3'b001;
            3'd1:    return 3'b010;
            default: return 3'b100;
        endcase
    endfunction

    function automatic logic [2:0] exp_sr(input logic [2:0] s);
        case (s)
            3'd3:    return 3'b001;
            3'd4:    return 3'b010;
            default: return 3'b100;
        endcase
    endfunction

    // Monitor: lamp table every cycle, and phase lengths against the expected queues.
    always @(negedge clk) begin
        if (!rst_n) begin
            check("rst_hw_a", hw_a, 3'b001);
            check("rst_sr_a", sr_a, 3'b100);
            check("rst_st_a", state_a, ST_HGRE);
            cur_a = 3'd0; len_a = 0;
            cur_b = 3'd0; len_b = 0;
        end else begin
            check("legal_a", state_a <= 3'd5, 1);
            check("hw_a", hw_a, exp_hw(state_a));
            check("sr_a", sr_a, exp_sr(state_a));
            check("walk_a", walk_a, ped_mode && state_a == 3'd3);
            check("hw_b", hw_b, exp_hw(state_b));
            check("sr_b", sr_b, exp_sr(state_b));
            check("walk_b", walk_b, ped_mode && state_b == 3'd3);
            if (state_b == 3'd2 || state_b == 3'd5) ared_seen_b = 1'b1;

            if (state_a != cur_a) begin
                if (q_a.size() == 0) begin
                    check("a_unexpected_phase_end", cur_a, 3'd7);
                end else begin
                    phase_t p;
                    p = q_a.pop_front();
                    check("a_phase_state", cur_a, p.st);
                    check("a_phase_len", len_a, p.len);
                end
                cur_a = state_a; len_a = 1;
            end else begin
                len_a++;
            end

            if (state_b != cur_b) begin
                if (q_b.size() == 0) begin
                    check("b_unexpected_phase_end", cur_b, 3'd7);
                end else begin
                    phase_t p;
                    p = q_b.pop_front();
                    check("b_phase_state", cur_b, p.st);
                    check("b_phase_len", len_b, p.len);
                end
                cur_b = state_b; len_b = 1;
            end else begin
                len_b++;
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk); #1;
        rst_n = 1'b0;
        idle(1);
        rst_n = 1'b1;
    endtask

    // Phases seen after a request whose HGRE lasted hg cycles (first HGRE after
    // reset is hg = leave_edge - 1 samples).
    task automatic push_cycle_a(input int hg);
        q_a.push_back(phase_t'{3'(ST_HGRE),  hg});
        q_a.push_back(phase_t'{3'(ST_HYEL),  12});
        q_a.push_back(phase_t'{3'(ST_ARED1), 4});
        q_a.push_back(phase_t'{3'(ST_SGRE),  40});
        q_a.push_back(phase_t'{3'(ST_SYEL),  12});
        q_a.push_back(phase_t'{3'(ST_ARED2), 4});
    endtask

    task automatic push_cycle_b(input int hg);
        q_b.push_back(phase_t'{3'(ST_HGRE), hg});
        q_b.push_back(phase_t'{3'(ST_HYEL), 12});
        q_b.push_back(phase_t'{3'(ST_SGRE), 40});
        q_b.push_back(phase_t'{3'(ST_SYEL), 12});
    endtask

    // Pulse one input for one cycle so it is sampled at edge k after reset release.
    // which: 0 = car_a, 1 = car_b, 2 = ped_req.
    task automatic pulse_at(input int k, input int which);
        idle(k - 1);
        case (which)
            0: car_a = 1'b1;
            1: car_b = 1'b1;
            default: ped_req = 1'b1;
        endcase
        idle(1);
        car_a = 1'b0; car_b = 1'b0; ped_req = 1'b0;
    endtask

    task automatic end_scenario(input string tag);
        check({tag, "_st_a"}, state_a, ST_HGRE);
        check({tag, "_st_b"}, state_b, ST_HGRE);
        check({tag, "_qa_left"}, q_a.size(), 0);
        check({tag, "_qb_left"}, q_b.size(), 0);
    endtask

    initial begin
        rst_n = 1'b0; car_a = 1'b0; car_b = 1'b0; ped_req = 1'b0;
        ped_mode = 1'b0; ared_seen_b = 1'b0;
        cur_a = 3'd0; cur_b = 3'd0; len_a = 0; len_b = 0;
        idle(2);
        rst_n = 1'b1;

        // 1: no request, highway stays green.
        idle(200);
        check("s1_walk_a", walk_a, 1'b0);
        end_scenario("s1");

        // 2: request at cycle 3, before min green expires: leave on edge 20.
        do_reset();
        push_cycle_a(19);
        pulse_at(3, 0);
        idle(110);
        end_scenario("s2");

        // 3: request at cycle 30, after min green: leave on the next tick edge, 32.
        do_reset();
        push_cycle_a(31);
        pulse_at(30, 0);
        idle(110);
        end_scenario("s3");

        // 3b: request on the min-green tick edge itself: transition that edge.
        do_reset();
        push_cycle_a(19);
        pulse_at(20, 0);
        idle(110);
        end_scenario("s3b");

        // 4: no all-red build: HYEL goes straight to SGRE.
        do_reset();
        ared_seen_b = 1'b0;
        push_cycle_b(19);
        pulse_at(3, 1);
        idle(110);
        check("s4_no_ared", ared_seen_b, 1'b0);
        end_scenario("s4");

        // 5: reset asserted mid side-green; outputs return at once, request is forgotten.
        do_reset();
        q_a.push_back(phase_t'{3'(ST_HGRE),  19});
        q_a.push_back(phase_t'{3'(ST_HYEL),  12});
        q_a.push_back(phase_t'{3'(ST_ARED1), 4});
        pulse_at(3, 0);
        idle(46);
        check("s5_in_sgre", state_a, ST_SGRE);
        @(negedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("s5_async_st", state_a, ST_HGRE);
        check("s5_async_hw", hw_a, 3'b001);
        check("s5_async_sr", sr_a, 3'b100);
        idle(1);
        rst_n = 1'b1;
        idle(80);
        end_scenario("s5");

        // 6: pedestrian request only.
        do_reset();
`ifdef TL_PED_EN
        ped_mode = 1'b1;
        push_cycle_a(19);
        push_cycle_b(19);
`endif
        pulse_at(3, 2);
        idle(110);
        check("s6_walk_end", walk_a, 1'b0);
        end_scenario("s6");
        ped_mode = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
